// File: rtl/seq_restoring_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_restoring_divider_if
//  Description : Start/done request and result bundle for the restoring divider.
//  Revision    : 1.0  initial release
// ============================================================================
interface seq_restoring_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // Requester side: drives the operands, observes status and results.
    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    // Divider side.
    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_restoring_divider
//  Description : Multi-cycle unsigned restoring divider, one quotient bit per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    seq_restoring_divider_if.slave  bus
);
    localparam int          CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_r;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic [WIDTH:0]   w_shift_r;
    logic [WIDTH+1:0] w_sum;
    logic             w_ge;
    logic [WIDTH:0]   w_r_next;
    logic [WIDTH-1:0] w_q_next;

    // Trial subtraction as R + ~D + 1; the carry out means R >= D.
    // A bit shifted out of R's top makes the partial remainder exceed any D.
    always_comb begin
        w_shift_r = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
        w_sum     = {1'b0, w_shift_r} + {1'b0, ~{1'b0, r_d}} + {{(WIDTH+1){1'b0}}, 1'b1};
        w_ge      = w_sum[WIDTH+1] | r_r[WIDTH];
        w_r_next  = w_ge ? w_sum[WIDTH:0] : w_shift_r;
        w_q_next  = {r_q[WIDTH-2:0], w_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_r         <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= bus.dividend;
                            r_dbz       <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_d     <= bus.divisor;
                            r_q     <= bus.dividend;
                            r_r     <= '0;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r_q   <= w_q_next;
                    r_r   <= w_r_next;
                    r_cnt <= r_cnt + CW'(1);
                    // Published results stay frozen until the final iteration lands.
                    if (r_cnt == c_last) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_r_next[WIDTH-1:0];
                        r_dbz       <= 1'b0;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_restoring_divider
//  Description : Directed and random checks of the restoring divider against arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_restoring_divider;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    logic [W-1:0] prev_q;
    logic [W-1:0] prev_r;

    seq_restoring_divider_if #(.WIDTH(W)) bus ();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One operation; results come from plain / and % on the operands.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit predriven, input int mid_iter,
                         input logic [W-1:0] a2, input logic [W-1:0] b2,
                         input bit chain, input logic [W-1:0] ca, input logic [W-1:0] cb);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
        int           elat;
        int           n;
        if (b == '0) begin
            eq = '1; er = a; edz = 1'b1; elat = 1;
        end else begin
            eq = a / b; er = a % b; edz = 1'b0; elat = W + 1;
        end
        if (!predriven) begin
            @(negedge clk);
            bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        end
        @(posedge clk);
        n = 1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
        while (bus.done !== 1'b1 && n < W + 6) begin
            chk({tag, " busy"}, 32'(bus.busy), 32'(1));
            chk({tag, " q hold"}, 32'(bus.quotient), 32'(prev_q));
            chk({tag, " r hold"}, 32'(bus.remainder), 32'(prev_r));
            if (n == mid_iter) begin
                bus.start = 1'b1; bus.dividend = a2; bus.divisor = b2;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(elat));
        chk({tag, " quotient"}, 32'(bus.quotient), 32'(eq));
        chk({tag, " remainder"}, 32'(bus.remainder), 32'(er));
        chk({tag, " dbz"}, 32'(bus.div_by_zero), 32'(edz));
        chk({tag, " busy@done"}, 32'(bus.busy), 32'(0));
        if (!edz)
            chk({tag, " invariant"}, 32'(bus.quotient) * 32'(b) + 32'(bus.remainder), 32'(a));
        prev_q = eq;
        prev_r = er;
        if (chain) begin
            bus.start = 1'b1; bus.dividend = ca; bus.divisor = cb;
        end else begin
            bus.start = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk({tag, " done pulse"}, 32'(bus.done), 32'(0));
        end
    endtask

    task automatic rst_mid(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        bit seen;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (k) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk("reset mid-run outputs",
               32'({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (W + 3) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk("no done after abort", 32'(seen), 32'(0));
        prev_q = '0;
        prev_r = '0;
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        n_cmp = 0;
        n_err = 0;
        prev_q = '0;
        prev_r = '0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (2) @(negedge clk);
        chk("reset outputs",
            32'({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder}), 32'(0));
        rst_n = 1'b1;

        do_op("100/7",   8'd100, 8'd7,   1'b0, -1, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
        do_op("255/1",   8'd255, 8'd1,   1'b0, -1, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
        do_op("5/9",     8'd5,   8'd9,   1'b0, -1, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
        do_op("255/255", 8'd255, 8'd255, 1'b0, -1, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
        do_op("37/0",    8'd37,  8'd0,   1'b0, -1, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
        do_op("200/3",   8'd200, 8'd3,   1'b0, -1, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
        do_op("200/3 ignore", 8'd200, 8'd3, 1'b0, 3, 8'd9, 8'd4, 1'b0, 8'd0, 8'd0);
        do_op("200/3 b2b", 8'd200, 8'd3, 1'b0, -1, 8'd0, 8'd0, 1'b1, 8'd50, 8'd6);
        do_op("50/6",    8'd50,  8'd6,   1'b1, -1, 8'd0, 8'd0, 1'b1, 8'd77, 8'd0);
        do_op("77/0 b2b", 8'd77, 8'd0,   1'b1, -1, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);

        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if (i % 50 == 25)
                rst_mid(a, (b == '0) ? 8'd1 : b, $urandom_range(0, W - 2));
            else
                do_op("rand", a, b, 1'b0, -1, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
